// File: rtl/ysyx_22041412_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// Optional early-out when |dividend| < |divisor|: define YSYX_22041412_DIV_EARLY_EN.
module ysyx_22041412_div #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            w_en,
   input  logic [XLEN-1:0] rsA,
   input  logic [XLEN-1:0] rsB,
   input  logic [2:0]      func3,
   output logic            ready,
   output logic [XLEN-1:0] result
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvd_q, dvs_q, rem_q, quo_q;
   logic            w_q, rem_sel_q, neg_quo_q, neg_rem_q;

   logic            sgn, neg_a, neg_b, b_zero, ovf, early;
   logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_val;
   logic [XLEN:0]   partial, diff;
   logic            ge;
   logic [XLEN-1:0] rem_nx, quo_nx;

   // Applies sign correction and the word-result sign extension.
   function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                           input logic nq, input logic nr,
                                           input logic sel_r, input logic w);
      logic [XLEN-1:0] raw;
      raw = sel_r ? (nr ? -r : r) : (nq ? -q : q);
      if (w) raw = {{HALF{raw[HALF-1]}}, raw[HALF-1:0]};
      return raw;
   endfunction

   always_comb begin
      sgn     = ~func3[0];
      op_a    = w_en ? {{HALF{sgn & rsA[HALF-1]}}, rsA[HALF-1:0]} : rsA;
      op_b    = w_en ? {{HALF{sgn & rsB[HALF-1]}}, rsB[HALF-1:0]} : rsB;
      neg_a   = sgn & op_a[XLEN-1];
      neg_b   = sgn & op_b[XLEN-1];
      mag_a   = neg_a ? -op_a : op_a;
      mag_b   = neg_b ? -op_b : op_b;
      min_val = w_en ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      b_zero  = (op_b == '0);
      ovf     = sgn & (op_a == min_val) & (op_b == '1);
`ifdef YSYX_22041412_DIV_EARLY_EN
      early   = (mag_a < mag_b);
`else
      early   = 1'b0;
`endif
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      partial = {rem_q, dvd_q[XLEN-1]};
      diff    = partial - {1'b0, dvs_q};
      ge      = ~diff[XLEN];
      rem_nx  = ge ? diff[XLEN-1:0] : partial[XLEN-1:0];
      quo_nx  = {quo_q[XLEN-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ready     <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         w_q       <= 1'b0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready  <= 1'b0;
               result <= '0;
               if (en) begin
                  // Word dividends sit in the upper half so the MSB-first shift works.
                  dvd_q     <= w_en ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                  dvs_q     <= mag_b;
                  rem_q     <= '0;
                  quo_q     <= '0;
                  w_q       <= w_en;
                  rem_sel_q <= func3[1];
                  neg_quo_q <= neg_a ^ neg_b;
                  neg_rem_q <= neg_a;
                  if (!func3[2]) begin
                     state <= DONE;
                     ready <= 1'b1;
                  end else if (b_zero) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= fmt('1, op_a, 1'b0, 1'b0, func3[1], w_en);
                  end else if (ovf) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= fmt(min_val, '0, 1'b0, 1'b0, func3[1], w_en);
                  end else if (early) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= fmt('0, op_a, 1'b0, 1'b0, func3[1], w_en);
                  end else begin
                     state <= CALC;
                     cnt   <= w_en ? CW'(HALF - 1) : CW'(XLEN - 1);
                  end
               end
            end
            CALC: begin
               if (!en) begin
                  state <= IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  dvd_q <= dvd_q << 1;
                  cnt   <= cnt - CW'(1);
                  if (cnt == '0) begin
                     state  <= DONE;
                     ready  <= 1'b1;
                     result <= fmt(quo_nx, rem_nx, neg_quo_q, neg_rem_q, rem_sel_q, w_q);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               ready  <= 1'b0;
               result <= '0;
            end
            default: begin
               state  <= IDLE;
               ready  <= 1'b0;
               result <= '0;
            end
         endcase
      end
   end

endmodule
